// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - request/response channel bundle for the register file access sequencer
interface regfile_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr_a;
    logic [ADDR_W-1:0] req_addr_b;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - register file access sequencer; WRITE_VERIFY_EN adds write readback check
module regfile_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_access_ctrl_if.slave bus,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_wa,
    output logic [DATA_W-1:0]    rf_wd,
    output logic [ADDR_W-1:0]    rf_ra1,
    output logic [ADDR_W-1:0]    rf_ra2,
    input  logic [DATA_W-1:0]    rf_rd1,
    input  logic [DATA_W-1:0]    rf_rd2,
    output logic [CNT_W-1:0]     txn_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_ISSUE, S_RD_CAPTURE, S_RSP
    } state_t;

    state_t            state, state_nxt;
    logic              accept, rsp_fire;
    logic              rsp_valid_q, rsp_valid_nxt;
    logic              rsp_err_q, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_nxt;
    logic [DATA_W-1:0] rsp_data_b_q, rsp_data_b_nxt;
    logic              rf_we_nxt;
    logic [ADDR_W-1:0] rf_wa_nxt, rf_ra1_nxt, rf_ra2_nxt;
    logic [DATA_W-1:0] rf_wd_nxt;
    logic [CNT_W-1:0]  txn_count_nxt;
    logic              verify_q, verify_nxt;

    assign bus.req_ready  = (state == S_IDLE) && reset;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_data_a = rsp_data_a_q;
    assign bus.rsp_data_b = rsp_data_b_q;
    assign accept         = bus.req_valid && bus.req_ready;
    assign rsp_fire       = rsp_valid_q && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
            rf_we        <= 1'b0;
            rf_wa        <= '0;
            rf_wd        <= '0;
            rf_ra1       <= '0;
            rf_ra2       <= '0;
            txn_count    <= '0;
            verify_q     <= 1'b0;
        end else begin
            state        <= state_nxt;
            rsp_valid_q  <= rsp_valid_nxt;
            rsp_err_q    <= rsp_err_nxt;
            rsp_data_a_q <= rsp_data_a_nxt;
            rsp_data_b_q <= rsp_data_b_nxt;
            rf_we        <= rf_we_nxt;
            rf_wa        <= rf_wa_nxt;
            rf_wd        <= rf_wd_nxt;
            rf_ra1       <= rf_ra1_nxt;
            rf_ra2       <= rf_ra2_nxt;
            txn_count    <= txn_count_nxt;
            verify_q     <= verify_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!bus.req_write)            state_nxt = S_RD_ISSUE;
                    else if (bus.req_addr_a == '0) state_nxt = S_RSP;
                    else                           state_nxt = S_WR;
                end
            end
`ifdef WRITE_VERIFY_EN
            S_WR:         state_nxt = S_RD_ISSUE;
`else
            S_WR:         state_nxt = S_RSP;
`endif
            S_RD_ISSUE:   state_nxt = S_RD_CAPTURE;
            S_RD_CAPTURE: state_nxt = S_RSP;
            S_RSP:        if (rsp_fire) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so valid/we line up with that state.
    always_comb begin
        rf_we_nxt      = (state_nxt == S_WR);
        rsp_valid_nxt  = (state_nxt == S_RSP);
        rf_wa_nxt      = rf_wa;
        rf_wd_nxt      = rf_wd;
        rf_ra1_nxt     = rf_ra1;
        rf_ra2_nxt     = rf_ra2;
        rsp_data_a_nxt = rsp_data_a_q;
        rsp_data_b_nxt = rsp_data_b_q;
        rsp_err_nxt    = rsp_err_q;
        verify_nxt     = verify_q;
        txn_count_nxt  = rsp_fire ? txn_count + CNT_W'(1) : txn_count;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    rsp_data_a_nxt = '0;
                    rsp_data_b_nxt = '0;
                    verify_nxt     = 1'b0;
                    if (bus.req_write) begin
                        rsp_err_nxt = (bus.req_addr_a == '0);
                        if (bus.req_addr_a != '0) begin
                            rf_wa_nxt = bus.req_addr_a;
                            rf_wd_nxt = bus.req_wdata;
                        end
                    end else begin
                        rsp_err_nxt = 1'b0;
                        rf_ra1_nxt  = bus.req_addr_a;
                        rf_ra2_nxt  = bus.req_addr_b;
                    end
                end
            end
            S_WR: begin
`ifdef WRITE_VERIFY_EN
                rf_ra1_nxt = rf_wa;
                verify_nxt = 1'b1;
`endif
            end
            S_RD_CAPTURE: begin
                rsp_data_a_nxt = rf_rd1;
                if (verify_q) begin
                    rsp_data_b_nxt = '0;
                    rsp_err_nxt    = (rf_rd1 != rf_wd);
                end else begin
                    rsp_data_b_nxt = rf_rd2;
                    rsp_err_nxt    = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule
